cdecn_dp: RTL and testbench
===========================

# cdecn_dp

Parametrised CDEC datapath: program counter, NGR general registers, T/R/I/MAR/WDR/RDR/FLG around a DW-bit ALU, all sourced from and written by a single XBUS driven by the sequencer's control word. Unlike the fixed 8-bit datapath, external memory is accessed through a req/ack handshake with timeout, and the sequencer is held by a `stall` output. An extended V (overflow) flag and a tri-state-free debug readout are provided.

## Interface
- `DW`, default 8: data, register and address width (8..32).
- `NGR`, default 3: general registers GR1..GRn (1..7).
- `MEM_TO`, default 15: cycles to wait for `mem_ack` before timeout (1..255).
- `clock`  in  1  single clock, rising edge.
- `reset_N`  in  1  one clock; reset is asynchronous and active-low.
- `ctrl`  in  17  {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]}.
- `adrs`  out  DW  MAR.
- `data_out`  out  DW  WDR.
- `data_in`  in  DW  read data, valid in the `mem_ack` cycle.
- `mem_rd` / `mem_wr`  out  1  access request, held until ack or timeout.
- `mem_ack`  in  1  access complete.
- `stall`  out  1  sequencer must hold `ctrl`.
- `mem_err`  out  1  sticky timeout flag.
- `I`  out  DW  instruction register.
- `SZCy`  out  3  FLG[3:1]; `V`  out  1  FLG[0].
- `resad`  in  8  debug address; `resdt`  out  DW  debug data.

## Operation
- xsrc: 0 PC, 1..NGR GRk, 8 R, 9 RDR, 10 FLG, all other codes all-ones. When xsrc=9 in an RD ack cycle, XBUS = `data_in` (forwarding).
- xdst: 0 PC, 1..NGR GRk, 8 MAR, 9 WDR, 10 T, 11 I, all other codes no write.
- `rwr`: R <= ALU(XBUS, T, Cy). `fwr`: FLG <= {0, S, Z, Cy, V}. S = msb, Z = result==0, Cy = carry/borrow out, V = signed overflow (0 for logic ops).
- mmrw: 00 none, 10 read, 01 write, 11 clear `mem_err`.
- Memory FSM states are IDLE, RD and WR:
  - IDLE: mmrw=10 -> RD; mmrw=01 -> WR.
  - RD/WR: on `mem_ack`, RD captures RDR <= `data_in`. A new mmrw accepted in that same cycle goes directly to RD/WR; otherwise the FSM returns to IDLE.
  - RD/WR: after MEM_TO cycles without ack, the FSM returns to IDLE and sets `mem_err`. On an RD timeout, RDR <= all-ones.
- `stall` = (state != IDLE) && !`mem_ack`. While `stall`=1, all xdst/rwr/fwr writes and mmrw are suppressed.
- `mem_err` is cleared by mmrw=11 or by reset. When clear and a timeout happen in the same cycle, the timeout wins.
- resad map:
  - 00 PC, 01 I, 02 T, 03 R, 04 MAR, 05 data_in, 06 RDR, 07 WDR.
  - 08..0A GR1..GR3, 0B FSM state, 0D FLG, 0E XBUS, 0F {mem_err, stall}.
  - 10+k GRk.
  - Unmapped or nonexistent addresses return 0.

## Timing
- Reset values: every register and all outputs are 0, FSM IDLE, `stall`=0, `mem_err`=0.
- Register write: one cycle; the value is visible on the next edge.
- Access accepted at edge N: `mem_rd`/`mem_wr` high from cycle N+1, `stall` high from N+1.
- Zero-wait ack in cycle N+1: `stall` is never seen high, and RDR is valid at edge N+2.
- Timeout counter starts at 0 on entry to RD/WR. Timeout fires in the cycle where count = MEM_TO-1 with no ack, so `stall` lasts exactly MEM_TO cycles.
- `mem_ack` in IDLE is ignored.
- Reset mid-access drops `mem_rd`/`mem_wr` immediately (asynchronous).
- All arithmetic is modulo 2^DW. PC has no auto-increment; increment is done through the ALU.

## Structure
- Package `cdec_pkg` holds:
  - xsrc/xdst code constants.
  - ALU op codes, including ALU_ADD, ALU_SUB, ALU_AND, ALU_PASS.
  - Memory FSM state enum and debug-address constants.
- Sub-module `cdecn_alu` (parameter DW) returns {S, Z, Cy, V, result}. Registers are plain always blocks in `cdecn_dp`.

## Test plan
- Reset: assert `reset_N`=0 mid-run -> PC, GRk and FLG read 0 via resdt; `mem_rd`=0; `stall`=0.
- ALU add with DW=8:
  - Setup: T=0x7F; GR1=0x01 via XBUS from R/ALU_PASS.
  - Stimulus: xsrc=GR1, ALU_ADD, rwr=fwr=1.
  - Expect: R=0x80, S=1, Z=0, Cy=0, V=1.
- Read with 3 wait states: MAR=0x40, mmrw=10, ack after 3 cycles with `data_in`=0xA5 -> `stall` high 3 cycles; forwarded XBUS=0xA5 in the ack cycle; RDR=0xA5; held xdst=GR2 write lands, so GR2=0xA5.
- Back-to-back: write (WDR=0x3C, zero-wait ack) with mmrw=10 in the ack cycle -> `mem_wr` then `mem_rd` in consecutive cycles, no IDLE gap.
- Timeout with MEM_TO=4: read, no ack -> `stall` high exactly 4 cycles; RDR=0xFF; `mem_err`=1. mmrw=11 -> `mem_err`=0.
- DW=16, NGR=7: write GR7=0xBEEF -> resad=0x17 returns 0xBEEF; resad=0x30 returns 0.

Source files
------------

// File: rtl/cdec_pkg.sv
// Shared codes for the CDEC datapath: bus source/destination selectors,
// ALU operations, memory handshake state and debug readout addresses.
package cdec_pkg;

  localparam logic [3:0] XS_PC  = 4'd0;
  localparam logic [3:0] XS_R   = 4'd8;
  localparam logic [3:0] XS_RDR = 4'd9;
  localparam logic [3:0] XS_FLG = 4'd10;

  localparam logic [3:0] XD_PC  = 4'd0;
  localparam logic [3:0] XD_MAR = 4'd8;
  localparam logic [3:0] XD_WDR = 4'd9;
  localparam logic [3:0] XD_T   = 4'd10;
  localparam logic [3:0] XD_I   = 4'd11;

  localparam logic [4:0] ALU_PASS  = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_ADC   = 5'd6;
  localparam logic [4:0] ALU_SBB   = 5'd7;
  localparam logic [4:0] ALU_INC   = 5'd8;
  localparam logic [4:0] ALU_DEC   = 5'd9;
  localparam logic [4:0] ALU_NOT   = 5'd10;
  localparam logic [4:0] ALU_PASST = 5'd11;

  localparam logic [1:0] MM_NONE = 2'b00;
  localparam logic [1:0] MM_RD   = 2'b10;
  localparam logic [1:0] MM_WR   = 2'b01;
  localparam logic [1:0] MM_CLR  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} mem_state_e;

  localparam logic [7:0] DA_PC    = 8'h00;
  localparam logic [7:0] DA_I     = 8'h01;
  localparam logic [7:0] DA_T     = 8'h02;
  localparam logic [7:0] DA_R     = 8'h03;
  localparam logic [7:0] DA_MAR   = 8'h04;
  localparam logic [7:0] DA_DIN   = 8'h05;
  localparam logic [7:0] DA_RDR   = 8'h06;
  localparam logic [7:0] DA_WDR   = 8'h07;
  localparam logic [7:0] DA_STATE = 8'h0B;
  localparam logic [7:0] DA_FLG   = 8'h0D;
  localparam logic [7:0] DA_XBUS  = 8'h0E;
  localparam logic [7:0] DA_STAT  = 8'h0F;

endpackage

// File: rtl/cdecn_alu.sv
// Combinational DW-bit ALU; result packed as {S, Z, Cy, V, value}.
module cdecn_alu
  import cdec_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] t,
  input  logic          cy_in,
  input  logic [4:0]    op,
  output logic [DW+3:0] res
);

  function automatic logic add_ovf(input logic signed [DW-1:0] a,
                                   input logic signed [DW-1:0] b,
                                   input logic signed [DW-1:0] r);
    return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [DW-1:0] a,
                                   input logic signed [DW-1:0] b,
                                   input logic signed [DW-1:0] r);
    return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  logic [DW:0]   ext;
  logic [DW-1:0] y;
  logic          c;
  logic          v;

  always_comb begin
    ext = '0;
    y   = x;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ALU_PASS:  y = x;
      ALU_PASST: y = t;
      ALU_ADD, ALU_ADC: begin
        ext = {1'b0, x} + {1'b0, t} + ((op == ALU_ADC) ? (DW+1)'(cy_in) : '0);
        y   = ext[DW-1:0];
        c   = ext[DW];
        v   = add_ovf(x, t, y);
      end
      ALU_SUB, ALU_SBB: begin
        // carry out of the extended subtract is the borrow
        ext = {1'b0, x} - {1'b0, t} - ((op == ALU_SBB) ? (DW+1)'(cy_in) : '0);
        y   = ext[DW-1:0];
        c   = ext[DW];
        v   = sub_ovf(x, t, y);
      end
      ALU_INC: begin
        ext = {1'b0, x} + (DW+1)'(1);
        y   = ext[DW-1:0];
        c   = ext[DW];
        v   = add_ovf(x, DW'(1), y);
      end
      ALU_DEC: begin
        ext = {1'b0, x} - (DW+1)'(1);
        y   = ext[DW-1:0];
        c   = ext[DW];
        v   = sub_ovf(x, DW'(1), y);
      end
      ALU_AND: y = x & t;
      ALU_OR:  y = x | t;
      ALU_XOR: y = x ^ t;
      ALU_NOT: y = ~x;
      default: y = x;
    endcase
  end

  assign res = {y[DW-1], (y == '0), c, v, y};

endmodule

// File: rtl/cdecn_dp.sv
// CDEC datapath: register file around a single XBUS and ALU, with a
// req/ack memory port that stalls the sequencer and times out.
module cdecn_dp
  import cdec_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NGR    = 3,
  parameter int MEM_TO = 15
) (
  input  logic          clock,
  input  logic          reset_N,
  input  logic [16:0]   ctrl,
  output logic [DW-1:0] adrs,
  output logic [DW-1:0] data_out,
  input  logic [DW-1:0] data_in,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_ack,
  output logic          stall,
  output logic          mem_err,
  output logic [DW-1:0] I,
  output logic [2:0]    SZCy,
  output logic          V,
  input  logic [7:0]    resad,
  output logic [DW-1:0] resdt
);

  logic [1:0] mmrw;
  logic       fwr, rwr;
  logic [3:0] xdst, xsrc;
  logic [4:0] aluop;
  assign {mmrw, fwr, rwr, xdst, aluop, xsrc} = ctrl;

  logic [DW-1:0] pc, t_reg, r_reg, i_reg, mar, wdr, rdr;
  logic [DW-1:0] gr [1:NGR];
  logic [3:0]    flg;
  logic [DW-1:0] xbus;
  logic [DW+3:0] alu_res;

  mem_state_e    state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic          err_nx;
  logic          rdr_ld;
  logic [DW-1:0] rdr_val;
  logic [1:0]    mm_eff;

  assign stall  = (state != ST_IDLE) && !mem_ack;
  assign mm_eff = stall ? MM_NONE : mmrw;

  always_comb begin
    xbus = '1;
    if (xsrc == XS_PC) xbus = pc;
    else if (xsrc == XS_R) xbus = r_reg;
    else if (xsrc == XS_RDR) xbus = (state == ST_RD && mem_ack) ? data_in : rdr;
    else if (xsrc == XS_FLG) xbus = DW'(flg);
    else begin
      for (int k = 1; k <= NGR; k++)
        if (xsrc == 4'(k)) xbus = gr[k];
    end
  end

  cdecn_alu #(.DW(DW)) u_alu (
    .x    (xbus),
    .t    (t_reg),
    .cy_in(flg[1]),
    .op   (aluop),
    .res  (alu_res)
  );

  // register file: every write is frozen while the sequencer is stalled
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pc    <= '0;
      t_reg <= '0;
      r_reg <= '0;
      i_reg <= '0;
      mar   <= '0;
      wdr   <= '0;
      flg   <= '0;
      for (int k = 1; k <= NGR; k++) gr[k] <= '0;
    end else if (!stall) begin
      if (xdst == XD_PC)  pc    <= xbus;
      if (xdst == XD_MAR) mar   <= xbus;
      if (xdst == XD_WDR) wdr   <= xbus;
      if (xdst == XD_T)   t_reg <= xbus;
      if (xdst == XD_I)   i_reg <= xbus;
      for (int k = 1; k <= NGR; k++)
        if (xdst == 4'(k)) gr[k] <= xbus;
      if (rwr) r_reg <= alu_res[DW-1:0];
      if (fwr) flg   <= alu_res[DW+3:DW];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = mem_err;
    rdr_ld   = 1'b0;
    rdr_val  = data_in;
    if (mm_eff == MM_CLR) err_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (mm_eff == MM_RD) state_nx = ST_RD;
        else if (mm_eff == MM_WR) state_nx = ST_WR;
      end
      ST_RD, ST_WR: begin
        if (mem_ack) begin
          rdr_ld = (state == ST_RD);
          cnt_nx = '0;
          if (mm_eff == MM_RD) state_nx = ST_RD;
          else if (mm_eff == MM_WR) state_nx = ST_WR;
          else state_nx = ST_IDLE;
        end else if (cnt == 8'(MEM_TO - 1)) begin
          // timeout overrides a clear in the same cycle
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          err_nx   = 1'b1;
          rdr_ld   = (state == ST_RD);
          rdr_val  = '1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
      rdr     <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mem_err <= err_nx;
      if (rdr_ld) rdr <= rdr_val;
    end
  end

  assign mem_rd   = (state == ST_RD);
  assign mem_wr   = (state == ST_WR);
  assign adrs     = mar;
  assign data_out = wdr;
  assign I        = i_reg;
  assign SZCy     = flg[3:1];
  assign V        = flg[0];

  always_comb begin
    resdt = '0;
    case (resad)
      DA_PC:    resdt = pc;
      DA_I:     resdt = i_reg;
      DA_T:     resdt = t_reg;
      DA_R:     resdt = r_reg;
      DA_MAR:   resdt = mar;
      DA_DIN:   resdt = data_in;
      DA_RDR:   resdt = rdr;
      DA_WDR:   resdt = wdr;
      DA_STATE: resdt = DW'(state);
      DA_FLG:   resdt = DW'(flg);
      DA_XBUS:  resdt = xbus;
      DA_STAT:  resdt = DW'({mem_err, stall});
      default:  resdt = '0;
    endcase
    for (int k = 1; k <= NGR; k++) begin
      if (k <= 3 && resad == 8'(7 + k)) resdt = gr[k];
      if (resad == 8'(16 + k)) resdt = gr[k];
    end
  end

endmodule

// File: tb/tb_cdecn_dp.sv
// Directed bench for cdecn_dp: stimulus queues expected values per cycle,
// an independent negedge monitor pops and compares them.
module tb_cdecn_dp;
  import cdec_pkg::*;

  logic        clock = 1'b0;
  logic        reset_N = 1'b1;
  int          cyc = 0;

  logic [16:0] ctrl8, ctrl16;
  logic [7:0]  adrs8, dout8, din8, i8, resdt8;
  logic [15:0] adrs16, dout16, din16, i16, resdt16;
  logic        rd8, wr8, ack8, stall8, merr8, v8;
  logic        rd16, wr16, ack16, stall16, merr16, v16;
  logic [2:0]  szcy8, szcy16;
  logic [7:0]  resad8, resad16;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cdecn_dp #(.DW(8), .NGR(3), .MEM_TO(4)) dut8 (
    .clock(clock), .reset_N(reset_N), .ctrl(ctrl8), .adrs(adrs8), .data_out(dout8),
    .data_in(din8), .mem_rd(rd8), .mem_wr(wr8), .mem_ack(ack8), .stall(stall8),
    .mem_err(merr8), .I(i8), .SZCy(szcy8), .V(v8), .resad(resad8), .resdt(resdt8));

  cdecn_dp #(.DW(16), .NGR(7), .MEM_TO(15)) dut16 (
    .clock(clock), .reset_N(reset_N), .ctrl(ctrl16), .adrs(adrs16), .data_out(dout16),
    .data_in(din16), .mem_rd(rd16), .mem_wr(wr16), .mem_ack(ack16), .stall(stall16),
    .mem_err(merr16), .I(i16), .SZCy(szcy16), .V(v16), .resad(resad16), .resdt(resdt16));

  localparam int S_RD8 = 0, S_RD16 = 1, S_STALL = 2, S_MRD = 3, S_MWR = 4, S_MERR = 5, S_FLG = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [16:0] cw(input logic [1:0] mm, input logic fw, input logic rw,
                                     input logic [3:0] dst, input logic [4:0] op,
                                     input logic [3:0] src);
    return {mm, fw, rw, dst, op, src};
  endfunction

  function automatic logic [16:0] nop();
    return cw(MM_NONE, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
  endfunction

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_RD8:   return 32'(resdt8);
      S_RD16:  return 32'(resdt16);
      S_STALL: return 32'(stall8);
      S_MRD:   return 32'(rd8);
      S_MWR:   return 32'(wr8);
      S_MERR:  return 32'(merr8);
      S_FLG:   return 32'({szcy8, v8});
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e   = sbq.pop_front();
      act = sample(e.sel);
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", e.name, act, e.val, e.cyc);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input bit w16, input logic [7:0] a, input logic [15:0] v, input string nm);
    if (w16) begin resad16 = a; push(S_RD16, 32'(v), nm); end
    else begin resad8 = a; push(S_RD8, 32'(v[7:0]), nm); end
  endtask

  // zero-wait read whose forwarded data is written to dst in the ack cycle
  task automatic load(input bit w16, input logic [3:0] dst, input logic [15:0] v);
    if (w16) ctrl16 = cw(MM_RD, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    else     ctrl8  = cw(MM_RD, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    step();
    if (w16) begin ack16 = 1'b1; din16 = v; ctrl16 = cw(MM_NONE, 1'b0, 1'b0, dst, ALU_PASS, XS_RDR); end
    else begin ack8 = 1'b1; din8 = v[7:0]; ctrl8 = cw(MM_NONE, 1'b0, 1'b0, dst, ALU_PASS, XS_RDR); end
    step();
    ack8 = 1'b0; ack16 = 1'b0;
    ctrl8 = nop(); ctrl16 = nop();
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [3:0] src, input logic [7:0] r_exp,
                        input logic [3:0] f_exp, input string nm);
    ctrl8 = cw(MM_NONE, 1'b1, 1'b1, 4'hF, op, src);
    step();
    ctrl8 = nop();
    peek(1'b0, DA_R, 16'(r_exp), {nm, "_r"});
    push(S_FLG, 32'(f_exp), {nm, "_flg"});
    step();
  endtask

  initial begin
    ctrl8 = nop(); ctrl16 = nop();
    din8 = '0; din16 = '0; ack8 = 1'b0; ack16 = 1'b0;
    resad8 = '0; resad16 = '0;
    #1 reset_N = 1'b0;
    step();
    push(S_MRD, 0, "rst_mem_rd"); push(S_STALL, 0, "rst_stall");
    push(S_MERR, 0, "rst_mem_err"); peek(1'b0, DA_PC, 16'h0, "rst_pc");
    step();
    reset_N = 1'b1;
    step();

    // ALU: T=0x7F, GR1=0x01 routed through R
    load(1'b0, XD_T, 16'h7F);
    peek(1'b0, DA_T, 16'h7F, "t_load");
    step();
    load(1'b0, 4'hF, 16'h01);
    ctrl8 = cw(MM_NONE, 1'b0, 1'b1, 4'hF, ALU_PASS, XS_RDR);
    step();
    ctrl8 = cw(MM_NONE, 1'b0, 1'b0, 4'd1, ALU_PASS, XS_R);
    step();
    ctrl8 = nop();
    peek(1'b0, 8'h08, 16'h01, "gr1_load");
    step();
    alu_op(ALU_ADD, 4'd1, 8'h80, 4'b1001, "add_ovf");
    alu_op(ALU_SUB, 4'd1, 8'h82, 4'b1010, "sub_borrow");
    alu_op(ALU_ADD, 4'hF, 8'h7E, 4'b0010, "add_carry");
    alu_op(ALU_INC, 4'hF, 8'h00, 4'b0110, "inc_zero");
    peek(1'b0, DA_FLG, 16'h06, "flg_readout");
    step();

    // read with 3 wait states, held GR2 write lands in the ack cycle
    load(1'b0, XD_MAR, 16'h40);
    peek(1'b0, DA_MAR, 16'h40, "mar_load");
    ctrl8 = cw(MM_RD, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    step();
    ctrl8 = cw(MM_NONE, 1'b0, 1'b0, 4'd2, ALU_PASS, XS_RDR);
    for (int w = 0; w < 3; w++) begin
      push(S_STALL, 1, "ws_stall");
      push(S_MRD, 1, "ws_mem_rd");
      step();
    end
    ack8 = 1'b1; din8 = 8'hA5;
    push(S_STALL, 0, "ws_ack_stall");
    peek(1'b0, DA_XBUS, 16'hA5, "ws_fwd_xbus");
    step();
    ack8 = 1'b0; ctrl8 = nop();
    peek(1'b0, DA_RDR, 16'hA5, "ws_rdr");
    push(S_MRD, 0, "ws_rd_drop");
    step();
    peek(1'b0, 8'h09, 16'hA5, "ws_gr2");
    step();

    // back-to-back write then read, zero-wait
    load(1'b0, XD_WDR, 16'h3C);
    ctrl8 = cw(MM_WR, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    step();
    ack8 = 1'b1;
    ctrl8 = cw(MM_RD, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    push(S_MWR, 1, "b2b_mem_wr"); push(S_STALL, 0, "b2b_wr_stall");
    peek(1'b0, DA_WDR, 16'h3C, "b2b_wdr");
    step();
    din8 = 8'h5A; ctrl8 = nop();
    push(S_MRD, 1, "b2b_mem_rd"); push(S_MWR, 0, "b2b_wr_drop");
    push(S_STALL, 0, "b2b_rd_stall");
    step();
    ack8 = 1'b0;
    peek(1'b0, DA_RDR, 16'h5A, "b2b_rdr");
    push(S_MRD, 0, "b2b_idle");
    step();

    // timeout after MEM_TO=4 stalled cycles
    ctrl8 = cw(MM_RD, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    step();
    ctrl8 = nop();
    for (int w = 0; w < 4; w++) begin
      push(S_STALL, 1, "to_stall");
      push(S_MERR, 0, "to_err_pre");
      step();
    end
    push(S_STALL, 0, "to_stall_end"); push(S_MRD, 0, "to_rd_drop");
    push(S_MERR, 1, "to_err_set"); peek(1'b0, DA_RDR, 16'hFF, "to_rdr");
    step();
    ctrl8 = cw(MM_CLR, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    peek(1'b0, DA_STAT, 16'h2, "to_dbg_stat");
    step();
    ctrl8 = nop();
    ack8 = 1'b1; din8 = 8'h77;
    push(S_MERR, 0, "err_clear");
    step();
    ack8 = 1'b0;
    peek(1'b0, DA_RDR, 16'hFF, "idle_ack_ignored");
    push(S_STALL, 0, "idle_ack_stall");
    step();

    // asynchronous reset in the middle of an access
    ctrl8 = cw(MM_NONE, 1'b0, 1'b0, XD_PC, ALU_PASS, 4'd1);
    step();
    ctrl8 = nop();
    peek(1'b0, DA_PC, 16'h01, "pc_write");
    step();
    peek(1'b0, 8'h11, 16'h01, "gr1_alias");
    step();
    peek(1'b0, 8'h17, 16'h00, "gr7_absent");
    ctrl8 = cw(MM_RD, 1'b0, 1'b0, 4'hF, ALU_PASS, XS_PC);
    step();
    ctrl8 = nop();
    push(S_MRD, 1, "pre_rst_rd");
    step();
    reset_N = 1'b0;
    push(S_MRD, 0, "async_rst_rd"); push(S_STALL, 0, "async_rst_stall");
    peek(1'b0, DA_PC, 16'h0, "rst_pc_mid");
    step();
    peek(1'b0, 8'h08, 16'h0, "rst_gr1");
    step();
    reset_N = 1'b1;
    peek(1'b0, DA_FLG, 16'h0, "rst_flg");
    push(S_FLG, 0, "rst_flg_out");
    step();

    // wide instance: DW=16, NGR=7
    load(1'b1, 4'd7, 16'hBEEF);
    peek(1'b1, 8'h17, 16'hBEEF, "w16_gr7");
    step();
    peek(1'b1, 8'h30, 16'h0000, "w16_unmapped");
    step();
    peek(1'b1, 8'h10, 16'h0000, "w16_gr0");
    step();
    peek(1'b1, DA_RDR, 16'hBEEF, "w16_rdr");
    step();
    step();

    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
